// File: rtl/upsample_pack_pkg.sv
// rtl/upsample_pack_pkg.sv - shared DWT synthesis-side constants and lane helper
package upsample_pack_pkg;

  localparam int LANES        = 6;
  localparam int COEF_PER_BLK = 3;
  localparam int SAMPLE_W     = 25;

  // Zero-insertion places coefficient k at lane 2k, shifted by one for odd phase.
  function automatic int lane_idx(input int k, input bit phase);
    return 2 * k + int'(phase);
  endfunction

endpackage

// File: rtl/upsample_pack_if.sv
// rtl/upsample_pack_if.sv - coefficient input and 6-lane block output bundle
interface upsample_pack_if
  import upsample_pack_pkg::*;
#(
  parameter int Y_W = SAMPLE_W
);

  logic signed [Y_W-1:0] Hi_A_y_in;
  logic signed [Y_W-1:0] Lo_A_y_in;
  logic                  in_valid;
  logic                  in_last;

  logic signed [Y_W-1:0] Hi_R_x_6k, Hi_R_x_6k_1, Hi_R_x_6k_2;
  logic signed [Y_W-1:0] Hi_R_x_6k_3, Hi_R_x_6k_4, Hi_R_x_6k_5;
  logic signed [Y_W-1:0] Lo_R_x_6k, Lo_R_x_6k_1, Lo_R_x_6k_2;
  logic signed [Y_W-1:0] Lo_R_x_6k_3, Lo_R_x_6k_4, Lo_R_x_6k_5;
  logic                  up_valid;
  logic                  up_last;
  logic                  busy;

  modport master (
    output Hi_A_y_in, Lo_A_y_in, in_valid, in_last,
    input  Hi_R_x_6k, Hi_R_x_6k_1, Hi_R_x_6k_2, Hi_R_x_6k_3, Hi_R_x_6k_4, Hi_R_x_6k_5,
    input  Lo_R_x_6k, Lo_R_x_6k_1, Lo_R_x_6k_2, Lo_R_x_6k_3, Lo_R_x_6k_4, Lo_R_x_6k_5,
    input  up_valid, up_last, busy
  );

  modport slave (
    input  Hi_A_y_in, Lo_A_y_in, in_valid, in_last,
    output Hi_R_x_6k, Hi_R_x_6k_1, Hi_R_x_6k_2, Hi_R_x_6k_3, Hi_R_x_6k_4, Hi_R_x_6k_5,
    output Lo_R_x_6k, Lo_R_x_6k_1, Lo_R_x_6k_2, Lo_R_x_6k_3, Lo_R_x_6k_4, Lo_R_x_6k_5,
    output up_valid, up_last, busy
  );

endinterface

// File: rtl/upsample_pack_lane_pack.sv
// rtl/upsample_pack_lane_pack.sv - one channel's staging slots and 6-lane output registers
module upsample_lane_pack
  import upsample_pack_pkg::*;
#(
  parameter int Y_W   = SAMPLE_W,
  parameter bit PHASE = 1'b0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [1:0]                       cnt_i,
  input  logic                             store_i,
  input  logic                             load_i,
  input  logic                             take_in_i,
  input  logic [Y_W-1:0]                   y_i,
  output logic [LANES-1:0][Y_W-1:0]        lane_o
);

  logic [COEF_PER_BLK-1:0][Y_W-1:0] stg_q, stg_d;
  logic [COEF_PER_BLK-1:0][Y_W-1:0] slot;
  logic [LANES-1:0][Y_W-1:0]        lane_q, lane_d;

  always_comb begin
    stg_d  = stg_q;
    lane_d = lane_q;
    slot   = '0;
    // Filled slots come from staging; the live input closes the block at slot cnt.
    for (int k = 0; k < COEF_PER_BLK; k++) begin
      if (2'(k) < cnt_i)
        slot[k] = stg_q[k];
      else if (2'(k) == cnt_i && take_in_i)
        slot[k] = y_i;
    end
    if (store_i)
      stg_d[cnt_i] = y_i;
    if (load_i) begin
      stg_d  = '0;
      lane_d = '0;
      for (int k = 0; k < COEF_PER_BLK; k++)
        lane_d[lane_idx(k, PHASE)] = slot[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_q  <= '0;
      lane_q <= '0;
    end else begin
      stg_q  <= stg_d;
      lane_q <= lane_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/upsample_pack.sv
// rtl/upsample_pack.sv - 2x zero-insertion upsampler packing Hi/Lo coefficients into 6-lane blocks
module upsample_pack
  import upsample_pack_pkg::*;
#(
  parameter int Y_W   = SAMPLE_W,
  parameter bit PHASE = 1'b0
) (
  input logic           clk,
  input logic           rstn,
  upsample_pack_if.slave bus
);

  logic [1:0] cnt_q, cnt_d;
  logic       up_valid_q, up_last_q, busy_q;
  logic       complete, accept, flush, load;
  logic [LANES-1:0][Y_W-1:0] hi_lane, lo_lane;

  assign complete = bus.in_valid && (cnt_q == 2'd2 || bus.in_last);
  assign accept   = bus.in_valid && !complete;
  // A standalone last only matters when something is staged.
  assign flush    = !bus.in_valid && bus.in_last && (cnt_q != 2'd0);
  assign load     = complete || flush;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = 2'd0;
    else if (accept)
      cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= 2'd0;
      up_valid_q <= 1'b0;
      up_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      up_valid_q <= load;
      up_last_q  <= complete ? bus.in_last : flush;
      busy_q     <= (cnt_d != 2'd0);
    end
  end

  upsample_lane_pack #(.Y_W(Y_W), .PHASE(PHASE)) u_hi (
    .clk      (clk),
    .rstn     (rstn),
    .cnt_i    (cnt_q),
    .store_i  (accept),
    .load_i   (load),
    .take_in_i(complete),
    .y_i      (bus.Hi_A_y_in),
    .lane_o   (hi_lane)
  );

  upsample_lane_pack #(.Y_W(Y_W), .PHASE(PHASE)) u_lo (
    .clk      (clk),
    .rstn     (rstn),
    .cnt_i    (cnt_q),
    .store_i  (accept),
    .load_i   (load),
    .take_in_i(complete),
    .y_i      (bus.Lo_A_y_in),
    .lane_o   (lo_lane)
  );

  assign bus.Hi_R_x_6k   = hi_lane[0];
  assign bus.Hi_R_x_6k_1 = hi_lane[1];
  assign bus.Hi_R_x_6k_2 = hi_lane[2];
  assign bus.Hi_R_x_6k_3 = hi_lane[3];
  assign bus.Hi_R_x_6k_4 = hi_lane[4];
  assign bus.Hi_R_x_6k_5 = hi_lane[5];
  assign bus.Lo_R_x_6k   = lo_lane[0];
  assign bus.Lo_R_x_6k_1 = lo_lane[1];
  assign bus.Lo_R_x_6k_2 = lo_lane[2];
  assign bus.Lo_R_x_6k_3 = lo_lane[3];
  assign bus.Lo_R_x_6k_4 = lo_lane[4];
  assign bus.Lo_R_x_6k_5 = lo_lane[5];
  assign bus.up_valid    = up_valid_q;
  assign bus.up_last     = up_last_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_upsample_pack.sv
// tb/tb_upsample_pack.sv - scoreboard bench driving PHASE=0 and PHASE=1 instances in lockstep
module tb_upsample_pack;

  localparam int W = 25;
  typedef logic [5:0][W-1:0] blk_t;
  typedef struct {
    blk_t lo;
    blk_t hi;
    logic last;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  upsample_pack_if #(.Y_W(W)) b0 ();
  upsample_pack_if #(.Y_W(W)) b1 ();

  upsample_pack #(.Y_W(W), .PHASE(1'b0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));
  upsample_pack #(.Y_W(W), .PHASE(1'b1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));

  blk_t lo0, hi0, lo1, hi1;
  assign lo0 = {b0.Lo_R_x_6k_5, b0.Lo_R_x_6k_4, b0.Lo_R_x_6k_3, b0.Lo_R_x_6k_2, b0.Lo_R_x_6k_1, b0.Lo_R_x_6k};
  assign hi0 = {b0.Hi_R_x_6k_5, b0.Hi_R_x_6k_4, b0.Hi_R_x_6k_3, b0.Hi_R_x_6k_2, b0.Hi_R_x_6k_1, b0.Hi_R_x_6k};
  assign lo1 = {b1.Lo_R_x_6k_5, b1.Lo_R_x_6k_4, b1.Lo_R_x_6k_3, b1.Lo_R_x_6k_2, b1.Lo_R_x_6k_1, b1.Lo_R_x_6k};
  assign hi1 = {b1.Hi_R_x_6k_5, b1.Hi_R_x_6k_4, b1.Hi_R_x_6k_3, b1.Hi_R_x_6k_2, b1.Hi_R_x_6k_1, b1.Hi_R_x_6k};

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  localparam logic signed [W-1:0] MINV = -(25'sd1 <<< 24);
  localparam logic signed [W-1:0] MAXV = (25'sd1 <<< 24) - 25'sd1;

  function automatic void chk(input string nm, input blk_t act, input blk_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endfunction

  task automatic set_in(input logic v, input logic l, input logic signed [W-1:0] lo, input logic signed [W-1:0] hi);
    b0.in_valid = v;  b1.in_valid = v;
    b0.in_last  = l;  b1.in_last  = l;
    b0.Lo_A_y_in = lo; b1.Lo_A_y_in = lo;
    b0.Hi_A_y_in = hi; b1.Hi_A_y_in = hi;
  endtask

  task automatic drive(input logic v, input logic l, input logic signed [W-1:0] lo, input logic signed [W-1:0] hi);
    set_in(v, l, lo, hi);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected block from three coefficients (a = slot 0); pushes both phase layouts.
  task automatic expect_blk(input logic signed [W-1:0] la, lb, lc, ha, hb, hc, input logic last);
    exp_t e;
    logic [W-1:0] z;
    z = '0;
    e.lo = {z, lc, z, lb, z, la};
    e.hi = {z, hc, z, hb, z, ha};
    e.last = last;
    q0.push_back(e);
    e.lo = {lc, z, lb, z, la, z};
    e.hi = {hc, z, hb, z, ha, z};
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.up_valid) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL p0 unexpected strobe: got up_valid=1 want 0");
      end else begin
        e = q0.pop_front();
        chk("p0 lo lanes", lo0, e.lo);
        chk("p0 hi lanes", hi0, e.hi);
        chk("p0 up_last", blk_t'(b0.up_last), blk_t'(e.last));
      end
    end
    if (b1.up_valid) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL p1 unexpected strobe: got up_valid=1 want 0");
      end else begin
        e = q1.pop_front();
        chk("p1 lo lanes", lo1, e.lo);
        chk("p1 hi lanes", hi1, e.hi);
        chk("p1 up_last", blk_t'(b1.up_last), blk_t'(e.last));
      end
    end
  end

  initial begin
    set_in(1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;

    // Reset state and idle behaviour
    chk("reset lanes p0", lo0 | hi0, '0);
    chk("reset lanes p1", lo1 | hi1, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle flags", blk_t'({b1.busy, b1.up_last, b1.up_valid, b0.busy, b0.up_last, b0.up_valid}), '0);
    end
    idle(1);

    // Full block of three
    expect_blk(5, -7, 9, 1, 2, 3, 1'b0);
    drive(1'b1, 1'b0, 5, 1);
    chk("busy after first", blk_t'({b1.busy, b0.busy}), blk_t'(2'b11));
    drive(1'b1, 1'b0, -7, 2);
    drive(1'b1, 1'b0, 9, 3);
    chk("busy after full", blk_t'({b1.busy, b0.busy}), '0);
    idle(3);

    // Partial block closed by in_last on the second valid
    expect_blk(4, 8, 0, 10, -20, 0, 1'b1);
    drive(1'b1, 1'b0, 4, 10);
    drive(1'b1, 1'b1, 8, -20);
    chk("busy after last", blk_t'({b1.busy, b0.busy}), '0);
    idle(2);

    // Standalone flush, then a second flush with nothing staged
    expect_blk(6, 0, 0, -1, 0, 0, 1'b1);
    drive(1'b1, 1'b0, 6, -1);
    idle(3);
    chk("busy before flush", blk_t'({b1.busy, b0.busy}), blk_t'(2'b11));
    drive(1'b0, 1'b1, 0, 0);
    idle(2);
    drive(1'b0, 1'b1, 0, 0);
    idle(3);

    // Gapped input with extreme values, last coefficient at cnt==2 with in_last
    expect_blk(MINV, MAXV, 123, MAXV, MINV, -1, 1'b1);
    drive(1'b1, 1'b0, MINV, MAXV);
    idle(3);
    drive(1'b1, 1'b0, MAXV, MINV);
    idle(4);
    chk("busy in gap", blk_t'({b1.busy, b0.busy}), blk_t'(2'b11));
    drive(1'b1, 1'b1, 123, -1);
    idle(2);

    // Single-coefficient blocks back to back: a strobe on consecutive cycles
    expect_blk(3, 0, 0, -3, 0, 0, 1'b1);
    expect_blk(-4, 0, 0, 44, 0, 0, 1'b1);
    drive(1'b1, 1'b1, 3, -3);
    drive(1'b1, 1'b1, -4, 44);
    idle(2);

    // Reset mid-block discards staging; next block starts at lane 0
    drive(1'b1, 1'b0, 7, -7);
    chk("busy before reset", blk_t'({b1.busy, b0.busy}), blk_t'(2'b11));
    rstn = 1'b0;
    #2;
    chk("busy in reset", blk_t'({b1.busy, b0.busy}), '0);
    chk("lanes in reset", lo0 | hi0 | lo1 | hi1, '0);
    idle(1);
    rstn = 1'b1;
    expect_blk(11, 12, 13, 21, 22, 23, 1'b0);
    drive(1'b1, 1'b0, 11, 21);
    drive(1'b1, 1'b0, 12, 22);
    drive(1'b1, 1'b0, 13, 23);
    idle(5);

    chk("p0 queue drained", blk_t'(q0.size()), '0);
    chk("p1 queue drained", blk_t'(q1.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
